// File: rtl/bcd_down_timer_if.sv
// Control and display bus of the BCD countdown timer.
// The master side issues load/start/pause/tick; the slave side returns the count and status.
interface bcd_down_timer_if #(
    parameter int DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  start;
    logic                  pause;
    logic                  tick;
    logic [4*DIGITS-1:0]   Q;
    logic                  running;
    logic                  done;
    logic                  zero;

    modport master (
        output load, load_val, start, pause, tick,
        input  Q, running, done, zero
    );

    modport slave (
        input  load, load_val, start, pause, tick,
        output Q, running, done, zero
    );
endinterface

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with load/start/pause control and an expiry pulse.
// It decrements with digit borrow and either stops at zero or reloads the preset.
module bcd_down_timer #(
    parameter int DIGITS      = 2,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic               ck,
    input  logic               rst,
    bcd_down_timer_if.slave    bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        EXPIRED
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   preset_q, preset_d;
    logic           done_q, done_d;
    logic           running_q;
    logic [W-1:0]   loadClean;
    logic [W-1:0]   countDec;
    logic           isZero;
    logic           isOne;

    // Digits above 9 are clamped to 9 so the count never holds an invalid BCD code.
    function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcdDecrement(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign loadClean = sanitize(bus.load_val);
    assign countDec  = bcdDecrement(count_q);
    assign isZero    = (count_q == '0);
    assign isOne     = (count_q == W'(1));

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        preset_d = preset_q;
        done_d   = 1'b0;

        if (bus.load) begin
            count_d  = loadClean;
            preset_d = loadClean;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.pause && bus.start && !isZero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state_d = HOLD;
                    end else if (bus.tick) begin
                        if (isOne) begin
                            done_d = 1'b1;
                            if (AUTO_RELOAD) begin
                                count_d = preset_q;
                            end else begin
                                count_d = '0;
                                state_d = EXPIRED;
                            end
                        end else begin
                            count_d = countDec;
                        end
                    end
                end
                HOLD: begin
                    if (bus.start && !bus.pause) begin
                        state_d = RUN;
                    end
                end
                EXPIRED: begin
                    state_d = EXPIRED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // running is registered from the next state so it lines up with the state register.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            preset_q  <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            preset_q  <= preset_d;
            done_q    <= done_d;
            running_q <= (state_d == RUN);
        end
    end

    assign bus.Q       = count_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.zero    = isZero;
endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: a stop-at-zero instance and an auto-reload instance,
// driven from vector tables whose expected outputs flow through a scoreboard queue.
module tb_bcd_down_timer;
    typedef struct {
        logic       rst;
        logic       load;
        logic [7:0] val;
        logic       start;
        logic       pause;
        logic       tick;
        logic [7:0] expQ;
        logic       expRun;
        logic       expDone;
        logic       expZero;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       run;
        logic       done;
        logic       zero;
    } exp_t;

    logic ck;
    logic rstA;
    logic rstB;
    int   total;
    int   bad;
    exp_t sb[$];
    vec_t vecsA[$];
    vec_t vecsB[$];

    bcd_down_timer_if #(.DIGITS(2)) ifA ();
    bcd_down_timer_if #(.DIGITS(2)) ifB ();

    bcd_down_timer #(.DIGITS(2), .AUTO_RELOAD(1'b0)) u_dutA (
        .ck  (ck),
        .rst (rstA),
        .bus (ifA)
    );

    bcd_down_timer #(.DIGITS(2), .AUTO_RELOAD(1'b1)) u_dutB (
        .ck  (ck),
        .rst (rstB),
        .bus (ifB)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    function automatic vec_t mk(input logic r, input logic ld, input logic [7:0] v,
                                input logic s, input logic p, input logic t,
                                input logic [7:0] q, input logic run,
                                input logic dn, input logic z);
        vec_t x;
        x.rst = r; x.load = ld; x.val = v; x.start = s; x.pause = p; x.tick = t;
        x.expQ = q; x.expRun = run; x.expDone = dn; x.expZero = z;
        return x;
    endfunction

    task automatic applyStimulus(input int sel, input vec_t v);
        exp_t e;
        @(negedge ck);
        rstA = 1'b0; ifA.load = 1'b0; ifA.load_val = 8'h00;
        ifA.start = 1'b0; ifA.pause = 1'b0; ifA.tick = 1'b0;
        rstB = 1'b0; ifB.load = 1'b0; ifB.load_val = 8'h00;
        ifB.start = 1'b0; ifB.pause = 1'b0; ifB.tick = 1'b0;
        if (sel == 0) begin
            rstA = v.rst; ifA.load = v.load; ifA.load_val = v.val;
            ifA.start = v.start; ifA.pause = v.pause; ifA.tick = v.tick;
        end else begin
            rstB = v.rst; ifB.load = v.load; ifB.load_val = v.val;
            ifB.start = v.start; ifB.pause = v.pause; ifB.tick = v.tick;
        end
        e.q = v.expQ; e.run = v.expRun; e.done = v.expDone; e.zero = v.expZero;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input int sel, input string tag);
        exp_t       e;
        logic [7:0] q;
        logic       r;
        logic       d;
        logic       z;
        @(posedge ck);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s scoreboard: got empty queue want entry", tag);
            return;
        end
        e = sb.pop_front();
        q = (sel == 0) ? ifA.Q       : ifB.Q;
        r = (sel == 0) ? ifA.running : ifB.running;
        d = (sel == 0) ? ifA.done    : ifB.done;
        z = (sel == 0) ? ifA.zero    : ifB.zero;
        total++;
        if (q !== e.q) begin
            bad++;
            $display("[TB] FAIL %s Q: got %h want %h", tag, q, e.q);
        end
        total++;
        if (r !== e.run) begin
            bad++;
            $display("[TB] FAIL %s running: got %b want %b", tag, r, e.run);
        end
        total++;
        if (d !== e.done) begin
            bad++;
            $display("[TB] FAIL %s done: got %b want %b", tag, d, e.done);
        end
        total++;
        if (z !== e.zero) begin
            bad++;
            $display("[TB] FAIL %s zero: got %b want %b", tag, z, e.zero);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        rstA = 1'b0; rstB = 1'b0;
        ifA.load = 1'b0; ifA.load_val = 8'h00; ifA.start = 1'b0; ifA.pause = 1'b0; ifA.tick = 1'b0;
        ifB.load = 1'b0; ifB.load_val = 8'h00; ifB.start = 1'b0; ifB.pause = 1'b0; ifB.tick = 1'b0;

        // Stop-at-zero instance: fields are rst,load,val,start,pause,tick | Q,running,done,zero.
        vecsA.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
        vecsA.push_back(mk(0, 1, 8'h12, 0, 0, 0, 8'h12, 0, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h12, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h11, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h10, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h09, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h08, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h07, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h06, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h05, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h04, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h03, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 1));
        vecsA.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 0, 1));
        vecsA.push_back(mk(0, 1, 8'h20, 0, 0, 0, 8'h20, 0, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h20, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h19, 1, 0, 0));
        vecsA.push_back(mk(0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
        vecsA.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1));
        vecsA.push_back(mk(0, 1, 8'h05, 0, 0, 0, 8'h05, 0, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h05, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h04, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h03, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h03, 0, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h03, 0, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h03, 0, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h03, 0, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h03, 0, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h03, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0, 0));
        vecsA.push_back(mk(0, 1, 8'hAF, 0, 0, 0, 8'h99, 0, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h99, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h98, 1, 0, 0));
        vecsA.push_back(mk(0, 1, 8'h07, 0, 0, 1, 8'h07, 0, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h07, 0, 0, 0));
        vecsA.push_back(mk(0, 1, 8'h01, 0, 0, 0, 8'h01, 0, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h01, 1, 0, 0));
        vecsA.push_back(mk(1, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 1));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
        vecsA.push_back(mk(0, 1, 8'h01, 0, 0, 0, 8'h01, 0, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h01, 1, 0, 0));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 1));
        vecsA.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 1));
        vecsA.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1));
        vecsA.push_back(mk(0, 1, 8'h03, 0, 0, 0, 8'h03, 0, 0, 0));
        vecsA.push_back(mk(0, 1, 8'hA3, 0, 0, 0, 8'h93, 0, 0, 0));

        // Auto-reload instance: wrap from 01 back to the preset, then a preset of 1 with tick held.
        vecsB.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
        vecsB.push_back(mk(0, 1, 8'h03, 0, 0, 0, 8'h03, 0, 0, 0));
        vecsB.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h03, 1, 0, 0));
        vecsB.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0, 0));
        vecsB.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0));
        vecsB.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h03, 1, 1, 0));
        vecsB.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0, 0));
        vecsB.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0));
        vecsB.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h03, 1, 1, 0));
        vecsB.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0, 0));
        vecsB.push_back(mk(0, 1, 8'h01, 0, 0, 0, 8'h01, 0, 0, 0));
        vecsB.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h01, 1, 0, 0));
        vecsB.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h01, 1, 1, 0));
        vecsB.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h01, 1, 1, 0));
        vecsB.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h01, 1, 1, 0));
        vecsB.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h01, 0, 0, 0));

        for (int i = 0; i < vecsA.size(); i++) begin
            applyStimulus(0, vecsA[i]);
            checkOutput(0, $sformatf("A%0d", i));
        end
        for (int i = 0; i < vecsB.size(); i++) begin
            applyStimulus(1, vecsB[i]);
            checkOutput(1, $sformatf("B%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
